// File: rtl/osp_converter.sv
// osp_converter: converts between an integer and a big-endian octet string of
// runtime length x_len (I2OSP / OS2IP). The byte reversal is the same in both
// directions, so one datapath serves both modes. BYTES_PER_CYCLE lanes are
// handled per clock, which gives a fixed latency of NBYTES/BYTES_PER_CYCLE.
//
// Handshake: a transfer happens on any rising clk edge where valid && ready.
// The upstream side may only be accepted in IDLE (in_ready = 1 there only).
// The result is offered in DONE with out_valid = 1. data_out and err stay
// stable until out_ready is seen, and only then does the block return to IDLE.
module osp_converter #(
    parameter int DATA_BIT_WIDTH  = 2048,
    parameter int BYTES_PER_CYCLE = 4,
    parameter int LEN_WIDTH       = 9
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      mode,
    input  logic [LEN_WIDTH-1:0]      x_len,
    input  logic [DATA_BIT_WIDTH-1:0] data_in,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_BIT_WIDTH-1:0] data_out,
    output logic                      err,
    output logic [1:0]                dbg_state,
    output logic                      dbg_mode
);
    localparam int NBYTES = DATA_BIT_WIDTH / 8;
    localparam int STEPS  = NBYTES / BYTES_PER_CYCLE;
    localparam int SW     = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam int AW     = $clog2(DATA_BIT_WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    // src_q is shifted down each RUN cycle so the current lanes sit at the bottom
    logic [DATA_BIT_WIDTH-1:0] src_q;
    logic [DATA_BIT_WIDTH-1:0] result_q;
    logic [LEN_WIDTH-1:0]      len_q;
    logic [LEN_WIDTH-1:0]      base_q;   // source lane index of src_q lane 0
    logic [SW-1:0]             step_q;
    logic                      mode_q;   // only tells which error cause applies
    logic                      err_q;    // sticky error of the transaction

    logic accept;
    logic last_step;
    logic len_bad;
    logic len_ok_q;

    logic [LEN_WIDTH-1:0] lane_idx [BYTES_PER_CYCLE];
    logic [LEN_WIDTH-1:0] dst_lane [BYTES_PER_CYCLE];
    logic [AW-1:0]        dst_bit  [BYTES_PER_CYCLE];
    logic                 lane_hit [BYTES_PER_CYCLE];
    logic                 lane_nz  [BYTES_PER_CYCLE];

    assign accept    = in_valid && in_ready;
    assign last_step = (step_q == SW'(STEPS - 1));
    assign len_bad   = (x_len == '0) || (x_len > LEN_WIDTH'(NBYTES));
    assign len_ok_q  = (len_q != '0) && (len_q <= LEN_WIDTH'(NBYTES));

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and handshake outputs
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (last_step) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Per-lane destination and error detection for the lanes handled this cycle
    always_comb begin
        for (int k = 0; k < BYTES_PER_CYCLE; k++) begin
            lane_idx[k] = base_q + LEN_WIDTH'(k);
            dst_lane[k] = len_q - LEN_WIDTH'(1) - lane_idx[k];
            dst_bit[k]  = AW'({dst_lane[k], 3'b000});
            lane_hit[k] = len_ok_q && (lane_idx[k] < len_q);
            lane_nz[k]  = (src_q[8*k +: 8] != 8'd0);
        end
    end

    // Capture on accept, then move BYTES_PER_CYCLE lanes per RUN cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            src_q    <= '0;
            result_q <= '0;
            len_q    <= '0;
            base_q   <= '0;
            step_q   <= '0;
            mode_q   <= 1'b0;
            err_q    <= 1'b0;
        end else if (accept) begin
            src_q    <= data_in;
            result_q <= '0;
            len_q    <= x_len;
            base_q   <= '0;
            step_q   <= '0;
            mode_q   <= mode;
            err_q    <= len_bad;
        end else if (state_q == RUN) begin
            src_q  <= src_q >> (8 * BYTES_PER_CYCLE);
            base_q <= base_q + LEN_WIDTH'(BYTES_PER_CYCLE);
            step_q <= step_q + 1'b1;
            for (int k = 0; k < BYTES_PER_CYCLE; k++) begin
                if (lane_hit[k]) begin
                    result_q[dst_bit[k] +: 8] <= src_q[8*k +: 8];
                end else if (lane_nz[k]) begin
                    err_q <= 1'b1;
                end
            end
        end
    end

    // An erroring transaction reports zero data; nothing is driven outside DONE
    assign data_out  = ((state_q == DONE) && !err_q) ? result_q : '0;
    assign err       = (state_q == DONE) && err_q;
    assign dbg_state = state_q;
    assign dbg_mode  = mode_q;

endmodule

// File: doc/osp_converter.md
Name: osp_converter

Overview:
- Parametrised successor to the fixed byte-copy integer/octet-string stage in the RSA datapath.
- Converts between an integer and a big-endian octet string of runtime length x_len, in either direction: I2OSP or OS2IP.
- Processes BYTES_PER_CYCLE octets per clock and flags "integer too large" / bad-length errors.
- Uses valid/ready handshakes on both sides, so it sits between the modexp core and the padding/hash blocks.

Parameters:
- DATA_BIT_WIDTH, 2048: integer / octet-string bus width; must be a multiple of 8. NBYTES = DATA_BIT_WIDTH/8.
- BYTES_PER_CYCLE, 4: octet lanes processed per cycle; must divide NBYTES. STEPS = NBYTES/BYTES_PER_CYCLE.
- LEN_WIDTH, 9: width of x_len; must hold NBYTES+1.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  request valid
- in_ready  out  1  block can accept a request
- mode  in  1  0 = I2OSP (integer -> octet string), 1 = OS2IP (octet string -> integer)
- x_len  in  LEN_WIDTH  octet-string length in octets
- data_in  in  DATA_BIT_WIDTH  source; octet-string lane j = data_in[8j+:8], where lane 0 is the first (most significant) octet
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- data_out  out  DATA_BIT_WIDTH  converted value, same lane convention
- err  out  1  error flag; qualified by out_valid

Behaviour:
- Clock and reset: clk; reset is synchronous, active-high.
- Reset values:
  - state = IDLE; in_ready = 1; out_valid = 0; err = 0; data_out = 0.
  - Internal step counter and result register = 0.
- FSM states IDLE, RUN, DONE:
  - IDLE: in_ready = 1. On in_valid && in_ready, capture data_in, x_len and mode; clear the result register and sticky error; step = 0; go to RUN.
  - RUN: in_ready = 0. Each cycle processes source lanes i = step*BPC .. step*BPC+BPC-1:
    - if i < x_len: result lane (x_len-1-i) <= src lane i;
    - else if src lane i != 0: sticky error <= 1.
    - step increments; after step STEPS-1 is processed, go to DONE.
  - DONE: out_valid = 1. data_out = result, or all zeros if the error is set; err = error. On out_valid && out_ready go to IDLE.
- Mapping: the reversal is identical in both modes. The mode bit only names the error cause and is not otherwise used in datapath arithmetic:
  - mode 0, nonzero byte above x_len: integer too large.
  - mode 1, nonzero octet beyond x_len: octet string longer than declared.
- Length error: x_len == 0 or x_len > NBYTES sets error at capture. Latency is unchanged; data_out = 0, err = 1.
- Latency:
  - Fixed: out_valid rises exactly STEPS clock edges after the accepting edge, independent of data and x_len. Default is 64.
  - At least one idle cycle between the out handshake and the next in_ready; no overlap of transactions.
- Backpressure: while in DONE with out_ready = 0, data_out and err hold stable and in_ready stays 0.
- Inputs are sampled only at the accepting edge. Later changes to data_in, x_len or mode have no effect on the transaction in flight.
- Reset in any state, including mid-RUN: the in-flight transaction is discarded and reset values apply on the next cycle.
- Output lanes >= x_len are always 0.

Test Plan:
- I2OSP (DW=2048, BPC=4): mode=0, x_len=4, data_in=0x0102 -> after 64 cycles out_valid=1, data_out=0x02010000, err=0.
- Too large: mode=0, x_len=4, data_in=0x1_0000_0000 -> err=1, data_out=0, latency still 64.
- OS2IP: mode=1, x_len=3, data_in[23:0]=0x030201 -> data_out=0x010203, err=0.
- Bad length: x_len=0, then x_len=257 -> both give err=1, data_out=0.
- Round trip with backpressure: random full-width x, x_len=256, I2OSP then OS2IP -> original x recovered.
  - Hold out_ready=0 for 10 cycles -> data_out stable and in_ready=0 throughout.
  - Repeat with BPC=1 (latency 256) and BPC=256 (latency 1).
- Reset mid-RUN at step 20: out_valid stays 0 and in_ready=1 on the next cycle; an immediately following request completes correctly.
